// File: rtl/ram_16x8_bit.sv
// ram_16x8_bit -- single-port synchronous RAM, 16 words x 8 bits.
//
// One address bus is shared by writes and reads. Read data is registered, so
// data appears one cycle after its address. Storage is a flop array, which
// makes the reset contents deterministic.
//
// Ports (header order; the first five may be connected positionally):
//   data_in       in   DATA_WIDTH  write data
//   ram_address   in   ADDR_WIDTH  word address for both write and read
//   write_enable  in   1           1 = write cycle, 0 = read cycle
//   clk           in   1           clock; all state changes on the rising edge
//   data_out      out  DATA_WIDTH  registered read data
//   rst_n         in   1           asynchronous active-low reset (clears memory and data_out)
//
// Build option:
//   RAM_WRITE_THROUGH_EN  when defined, a write cycle also loads data_in into
//                         data_out. When undefined (default), data_out holds
//                         during write cycles. The memory is written identically
//                         in both modes.
module ram_16x8_bit #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] ram_address,
   input  logic                  write_enable,
   input  logic                  clk,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  rst_n
);

   // Depth always follows the address width.
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write and read are decoded as two explicit compares, not as if/else.
   // An unknown write_enable therefore matches neither branch. In that case
   // nothing is written and data_out holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_enable == 1'b1) begin
         mem[ram_address] <= data_in;
`ifdef RAM_WRITE_THROUGH_EN
         data_out <= data_in;
`endif
      end else if (write_enable == 1'b0) begin
         data_out <= mem[ram_address];
      end
   end

endmodule

// File: tb/tb_ram_16x8_bit.sv
module tb_ram_16x8_bit;

   logic [7:0] data_in;
   logic [3:0] ram_address;
   logic       write_enable;
   logic       clk;
   logic [7:0] data_out;
   logic       rst_n;

   int tests = 0;
   int fails = 0;

   // Reference model: the memory as a plain array plus the expected output.
   logic [7:0] m [16];
   logic [7:0] eo;

`ifdef RAM_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   ram_16x8_bit dut (
      .data_in      (data_in),
      .ram_address  (ram_address),
      .write_enable (write_enable),
      .clk          (clk),
      .data_out     (data_out),
      .rst_n        (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      foreach (m[i]) m[i] = 8'h00;
      eo = 8'h00;
   endtask

   // Runs one access, which is one clock edge.
   // The inputs change 1 time unit after the edge.
   // After the edge, the model is updated and the DUT output is checked against it.
   task automatic cycle(input logic we, input logic [3:0] addr, input logic [7:0] din);
      write_enable = we;
      ram_address  = addr;
      data_in      = din;
      @(posedge clk);
      if (rst_n) begin
         if (we) begin
            m[addr] = din;
            if (WT) eo = din;
         end else begin
            eo = m[addr];
         end
      end
      #1 chk("model", data_out, eo);
   endtask

   initial begin
      rst_n        = 1'b0;
      write_enable = 1'b0;
      ram_address  = '0;
      data_in      = '0;
      model_clear();
      #1 chk("reset_out", data_out, 8'h00);

      // 1: reset pulse, then read 0, 5 and 15.
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 4'd0, 8'h00);  chk("t1_rd0", data_out, 8'h00);
      cycle(1'b0, 4'd5, 8'h00);  chk("t1_rd5", data_out, 8'h00);
      cycle(1'b0, 4'd15, 8'h00); chk("t1_rd15", data_out, 8'h00);

      // 2: three writes, then read them back.
      cycle(1'b1, 4'd0, 8'h10);
      cycle(1'b1, 4'd2, 8'h11);
      cycle(1'b1, 4'd7, 8'hAF);
      cycle(1'b0, 4'd0, 8'h00); chk("t2_rd0", data_out, 8'h10);
      cycle(1'b0, 4'd2, 8'h00); chk("t2_rd2", data_out, 8'h11);
      cycle(1'b0, 4'd7, 8'h00); chk("t2_rd7", data_out, 8'hAF);

      // 3: overwrite an address, and read an address never written.
      cycle(1'b1, 4'd3, 8'h55);
      cycle(1'b1, 4'd3, 8'hAA);
      cycle(1'b0, 4'd3, 8'h00); chk("t3_rd3", data_out, 8'hAA);
      cycle(1'b0, 4'd4, 8'h00); chk("t3_rd4", data_out, 8'h00);

      // 4: address boundaries.
      cycle(1'b1, 4'd0, 8'h01);
      cycle(1'b1, 4'd15, 8'hFE);
      cycle(1'b0, 4'd15, 8'h00); chk("t4_rd15", data_out, 8'hFE);
      cycle(1'b0, 4'd0, 8'h00);  chk("t4_rd0", data_out, 8'h01);

      // 5: data_out during a write cycle (hold, or write-through when the option is built in).
      cycle(1'b0, 4'd7, 8'h00); chk("t5_rd7", data_out, 8'hAF);
      cycle(1'b1, 4'd9, 8'h33); chk("t5_wr9", data_out, WT ? 8'h33 : 8'hAF);
      cycle(1'b0, 4'd9, 8'h00); chk("t5_rd9", data_out, 8'h33);

      // 6: write, then reset between edges.
      cycle(1'b0, 4'd7, 8'h00);
      cycle(1'b1, 4'd6, 8'hC3);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_clr", data_out, 8'h00);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 4'd6, 8'h00); chk("t6_rd6", data_out, 8'h00);

      // Random traffic with occasional asynchronous resets.
      // Each reset is held across an edge that carries a write, so that write must be discarded.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 3) begin
            #2 rst_n = 1'b0;
            #1 chk("rand_async_clr", data_out, 8'h00);
            model_clear();
            cycle(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)));
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
         end
      end

      // Final sweep: read every address and compare against the model.
      for (int a = 0; a < 16; a++) begin
         cycle(1'b0, 4'(a), 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
